// File: rtl/btn_debouncer_sync.sv
// btn_debouncer_sync
// Two-flop synchroniser followed by a stable-time counter. The clean level
// changes only after the synchronised input has disagreed with it on
// DEBOUNCE_CYCLES consecutive clock edges. Any single cycle of agreement
// restarts the count. One-cycle strobes mark each change of the clean level.
module btn_debouncer_sync #(
  parameter int CLK_FREQ_HZ     = 100_000_000,
  parameter int DEBOUNCE_US     = 100,
  parameter int DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1_000_000 * DEBOUNCE_US
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic BTN,
  output logic BTN_DBOUN,
  output logic BTN_RISE,
  output logic BTN_FALL
);

  // The counter only has to reach N-1. Its width is clog2(N+1), so N=1
  // still gets a 1-bit counter.
  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             btn_sync;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             dbo_reg;
  logic             dbo_next;
  logic             rise_reg;
  logic             rise_next;
  logic             fall_reg;
  logic             fall_next;

  // Only the second synchroniser stage feeds the debounce logic.
  assign btn_sync = sync_reg[1];

  // Bring the asynchronous pad level into the CLK domain.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], BTN};
    end
  end

  // Count consecutive disagreements and commit the new level on the Nth one.
  always_comb begin
    cnt_next  = '0;
    dbo_next  = dbo_reg;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (btn_sync != dbo_reg) begin
      if (cnt_reg >= CNT_LAST) begin
        // The counter clears together with the level change. This keeps
        // level changes at least N cycles apart.
        dbo_next  = btn_sync;
        rise_next = btn_sync;
        fall_next = ~btn_sync;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  // Hold the counter, the clean level and the strobes. The strobes are
  // registered with the level, so they line up with the first cycle of the
  // new value.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_reg  <= '0;
      dbo_reg  <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      dbo_reg  <= dbo_next;
      rise_reg <= rise_next;
      fall_reg <= fall_next;
    end
  end

  assign BTN_DBOUN = dbo_reg;
  assign BTN_RISE  = rise_reg;
  assign BTN_FALL  = fall_reg;

endmodule

// File: tb/tb_btn_debouncer_sync.sv
// tb_btn_debouncer_sync
// Directed test of the debouncer with a short stable count, N = 16.
// Latency convention: BTN changes just after an edge, and "edge k" is the
// next edge. The clean level must change at edge k+N+1, so the measured
// latency is (edge of change) - (drive edge) - 1 = N+1.
module tb_btn_debouncer_sync;

  localparam int N = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic btn   = 1'b0;
  logic dbo;
  logic rise;
  logic fall;

  btn_debouncer_sync #(
    .CLK_FREQ_HZ    (100_000_000),
    .DEBOUNCE_US    (100),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .CLK      (clk),
    .RSTN     (rst_n),
    .BTN      (btn),
    .BTN_DBOUN(dbo),
    .BTN_RISE (rise),
    .BTN_FALL (fall)
  );

  always #5 clk = ~clk;

  // Free-running edge counter. It is read after each edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge. It keeps running totals of strobes and
  // high cycles, and records the edge index of the latest strobe. It also
  // counts protocol violations:
  //  - both strobes at once
  //  - a strobe that disagrees with the level
  //  - any output high during reset
  int rise_tot = 0;
  int fall_tot = 0;
  int high_tot = 0;
  int bad_tot  = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  always @(negedge clk) begin
    if (rise === 1'b1) begin
      rise_tot = rise_tot + 1;
      rise_cyc = cyc;
    end
    if (fall === 1'b1) begin
      fall_tot = fall_tot + 1;
      fall_cyc = cyc;
    end
    if (dbo === 1'b1) high_tot = high_tot + 1;
    if ((rise === 1'b1) && (fall === 1'b1)) bad_tot = bad_tot + 1;
    if ((rise === 1'b1) && (dbo !== 1'b1)) bad_tot = bad_tot + 1;
    if ((fall === 1'b1) && (dbo !== 1'b0)) bad_tot = bad_tot + 1;
    if ((rst_n === 1'b0) && ((dbo !== 1'b0) || (rise !== 1'b0) || (fall !== 1'b0)))
      bad_tot = bad_tot + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Change BTN just after an edge. Return that edge's index.
  task automatic drive(input logic v, output int at);
    @(posedge clk);
    #1;
    btn = v;
    at  = cyc;
  endtask

  // High for exactly len sampling edges.
  task automatic pulse(input int len, output int t_on, output int t_off);
    drive(1'b1, t_on);
    idle(len - 1);
    drive(1'b0, t_off);
  endtask

  int t_a, t_b, rel, b_rise, b_fall, b_high;

  task automatic snap();
    b_rise = rise_tot;
    b_fall = fall_tot;
    b_high = high_tot;
  endtask

  initial begin
    // 1: reset with the button held, then release.
    btn = 1'b1;
    #1 rst_n = 1'b0;
    idle(20);
    #1;
    check("t1_rst_dbo", {31'd0, dbo}, 32'd0);
    check("t1_rst_strobes", {30'd0, rise, fall}, 32'd0);
    snap();
    @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    idle(N + 8);
    #1;
    check("t1_dbo_after_release", {31'd0, dbo}, 32'd1);
    check("t1_rise_count", rise_tot - b_rise, 1);
    check("t1_rise_latency", rise_cyc - rel - 1, N + 1);
    drive(1'b0, t_a);
    idle(N + 8);

    // 2: clean press held 5N cycles.
    snap();
    pulse(5 * N, t_a, t_b);
    idle(2 * N);
    check("t2_high_cycles", high_tot - b_high, 5 * N);
    check("t2_rise_count", rise_tot - b_rise, 1);
    check("t2_fall_count", fall_tot - b_fall, 1);
    check("t2_rise_latency", rise_cyc - t_a - 1, N + 1);
    check("t2_fall_latency", fall_cyc - t_b - 1, N + 1);

    // 3a: glitch one cycle short of the threshold is ignored.
    snap();
    pulse(N - 1, t_a, t_b);
    idle(3 * N);
    check("t3_short_high", high_tot - b_high, 0);
    check("t3_short_strobes", (rise_tot - b_rise) + (fall_tot - b_fall), 0);

    // 3b: exactly N cycles passes through with equal width.
    snap();
    pulse(N, t_a, t_b);
    idle(3 * N);
    check("t3_exact_high", high_tot - b_high, N);
    check("t3_exact_rise", rise_tot - b_rise, 1);
    check("t3_exact_fall", fall_tot - b_fall, 1);

    // 4: bounce, toggling every 5 edges, ending high after 13 toggles.
    snap();
    for (int i = 0; i < 13; i++) begin
      drive(~btn, t_a);
      if (i < 12) idle(4);
    end
    idle(N + 8);
    check("t4_rise_count", rise_tot - b_rise, 1);
    check("t4_fall_count", fall_tot - b_fall, 0);
    check("t4_rise_latency", rise_cyc - t_a - 1, N + 1);
    drive(1'b0, t_b);
    idle(N + 8);
    check("t4_release_fall", fall_tot - b_fall, 1);

    // 5: train of three 2N-high pulses separated by 2N lows.
    snap();
    for (int i = 0; i < 3; i++) begin
      pulse(2 * N, t_a, t_b);
      idle(2 * N - 1);
    end
    idle(N + 4);
    check("t5_rise_count", rise_tot - b_rise, 3);
    check("t5_fall_count", fall_tot - b_fall, 3);
    check("t5_high_cycles", high_tot - b_high, 6 * N);
    #1;
    check("t5_ends_low", {31'd0, dbo}, 32'd0);

    // 6a: reset in the middle of a count discards it.
    snap();
    drive(1'b1, t_a);
    idle(N / 2);
    #3 rst_n = 1'b0;
    idle(3);
    #1;
    check("t6_dbo_in_reset", {31'd0, dbo}, 32'd0);
    check("t6_rise_in_reset", rise_tot - b_rise, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    idle(N + 8);
    check("t6_rise_latency", rise_cyc - rel - 1, N + 1);
    check("t6_rise_count", rise_tot - b_rise, 1);

    // 6b: reset while the level is high must not emit a fall strobe.
    snap();
    @(posedge clk);
    #3 rst_n = 1'b0;
    btn = 1'b0;
    idle(2);
    #1;
    check("t6_dbo_cleared", {31'd0, dbo}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(N + 8);
    check("t6_no_fall_strobe", fall_tot - b_fall, 0);
    check("t6_no_rise_strobe", rise_tot - b_rise, 0);

    check("protocol_violations", bad_tot, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
